// File: rtl/ibuf_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ibuf_conditioner_pkg
//  Purpose  : Shared defaults and helpers for the input-pad conditioner.
//             - DEF_* constants are the default parameter values.
//             - cnt_width() sizes the optional glitch-filter counter.
//  Options  : GLITCH_FILTER_EN (macro) enables the per-bit glitch filter.
//  Revision : 1.0  initial release
// ============================================================================
package ibuf_conditioner_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 4;

  // Width of a counter that must hold values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage : ibuf_conditioner_pkg
`default_nettype wire

// File: rtl/ibuf_cond_bit.sv
`default_nettype none
// ============================================================================
//  Module   : ibuf_cond_bit
//  Purpose  : Conditions one asynchronous pad bit into the clock domain:
//             synchroniser chain, optional glitch filter, history flop and
//             one-cycle rise/fall strobes.
//  Ports    : clock      - system clock (posedge)
//             reset      - asynchronous, active-high reset
//             pad_in     - raw pad bit, asynchronous to clock
//             sync_out   - synchronised (optionally filtered) level
//             rise_pulse - high for the first cycle sync_out is 1 after 0
//             fall_pulse - high for the first cycle sync_out is 0 after 1
//  Options  : GLITCH_FILTER_EN (macro) adds the FILTER_CYCLES stability filter.
//  Revision : 1.0  initial release
// ============================================================================
module ibuf_cond_bit
  import ibuf_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   candidate;
  logic                   prev_q, prev_d;
  logic                   level;

  // Synchroniser: stage 0 samples the pad, the last stage is the candidate.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else       sync_q <= sync_d;
  end

  assign candidate = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int CNT_W = cnt_width(FILTER_CYCLES);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter runs only while candidate disagrees with the filtered level;
  // on its FILTER_CYCLES-th consecutive disagreeing edge the level flips.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (candidate != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        filt_d = candidate;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= RESET_LEVEL;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  // Filter length is only meaningful when the filter is built.
  logic unused_filter_cfg;
  assign unused_filter_cfg = (FILTER_CYCLES != 0);
  assign level             = candidate;
`endif

  // History flop: sync_out as seen one cycle ago.
  always_comb begin
    prev_d = level;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= RESET_LEVEL;
    else       prev_q <= prev_d;
  end

  assign sync_out   = level;
  assign rise_pulse =  level & ~prev_q;
  assign fall_pulse = ~level &  prev_q;

endmodule : ibuf_cond_bit
`default_nettype wire

// File: rtl/ibuf_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : ibuf_conditioner
//  Purpose  : Input-pad conditioning at the FPGA boundary. Gives each pad a
//             raw combinational view, a clock-capable pass-through, and a
//             synchronised level with one-cycle edge strobes.
//  Ports    : clock      - system clock (posedge)
//             reset      - asynchronous, active-high reset
//             pad_in     - [WIDTH] raw pad inputs, asynchronous to clock
//             gclk_pad   - clock-capable pad input
//             raw_out    - [WIDTH] combinational copy of pad_in
//             gclk_out   - combinational copy of gclk_pad
//             sync_out   - [WIDTH] synchronised (optionally filtered) level
//             rise_pulse - [WIDTH] one-cycle 0->1 strobe per bit
//             fall_pulse - [WIDTH] one-cycle 1->0 strobe per bit
//  Options  : GLITCH_FILTER_EN (macro) enables the per-bit glitch filter.
//  Revision : 1.0  initial release
// ============================================================================
module ibuf_conditioner
  import ibuf_conditioner_pkg::*;
#(
  parameter int   WIDTH         = DEF_WIDTH,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             gclk_pad,
  output logic [WIDTH-1:0] raw_out,
  output logic             gclk_out,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Pure pass-throughs: valid regardless of clock or reset.
  assign raw_out  = pad_in;
  assign gclk_out = gclk_pad;

  // Bits are conditioned independently; no cross-bit coherency.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ibuf_cond_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_LEVEL   (RESET_LEVEL),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_bit (
      .clock      (clock),
      .reset      (reset),
      .pad_in     (pad_in[i]),
      .sync_out   (sync_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end : g_bit

endmodule : ibuf_conditioner
`default_nettype wire

// File: tb/tb_ibuf_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibuf_conditioner
//  Purpose  : Directed self-checking bench for ibuf_conditioner.
//  Options  : GLITCH_FILTER_EN (macro) selects the filtered expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ibuf_conditioner;

  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int FC    = 4;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = SS + FC;   // edges from first sampling edge to new level
`else
  localparam int LAT = SS;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pad_in;
  logic             gclk_pad;
  logic [WIDTH-1:0] raw_out;
  logic             gclk_out;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  int n_checks = 0;
  int n_errors = 0;

  ibuf_conditioner #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SS),
    .RESET_LEVEL   (1'b0),
    .FILTER_CYCLES (FC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pad_in     (pad_in),
    .gclk_pad   (gclk_pad),
    .raw_out    (raw_out),
    .gclk_out   (gclk_out),
    .sync_out   (sync_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] s,
                            input logic [7:0] r, input logic [7:0] f);
    check({tag, ".sync"}, {24'd0, sync_out},   {24'd0, s});
    check({tag, ".rise"}, {24'd0, rise_pulse}, {24'd0, r});
    check({tag, ".fall"}, {24'd0, fall_pulse}, {24'd0, f});
  endtask

  // Apply a new pad value and check the level change appears exactly LAT
  // edges later with a single-cycle strobe.
  task automatic step(input string tag, input logic [7:0] old_v, input logic [7:0] new_v);
    pad_in = new_v;
    repeat (LAT - 1) tick();
    check_outs({tag, ".before"}, old_v, 8'h00, 8'h00);
    tick();
    check_outs({tag, ".edge"}, new_v, new_v & ~old_v, ~new_v & old_v);
    tick();
    check_outs({tag, ".after"}, new_v, 8'h00, 8'h00);
  endtask

  initial begin
    // 1: reset held, pass-throughs live, registered outputs at reset level
    reset    = 1'b1;
    pad_in   = 8'hFF;
    gclk_pad = 1'b0;
    #2;
    check("t1.raw", {24'd0, raw_out}, 32'h0000_00FF);
    check("t1.gclk0", {31'd0, gclk_out}, 32'd0);
    gclk_pad = 1'b1;
    #1;
    check("t1.gclk1", {31'd0, gclk_out}, 32'd1);
    tick();
    gclk_pad = 1'b0;
    #1;
    check("t1.gclk2", {31'd0, gclk_out}, 32'd0);
    check_outs("t1", 8'h00, 8'h00, 8'h00);

    // 2: release reset with bit 0 high
    pad_in = 8'h00;
    tick();
    #2 reset = 1'b0;
    tick();
    check_outs("t2.idle", 8'h00, 8'h00, 8'h00);
    step("t2", 8'h00, 8'h01);
    tick();
    check_outs("t2.hold", 8'h01, 8'h00, 8'h00);

    // 3: falling edge on bit 0
    step("t3", 8'h01, 8'h00);

    // 4: rise strobe live, then asynchronous reset between edges
    pad_in = 8'hA5;
    repeat (LAT) tick();
    check_outs("t4.pre", 8'hA5, 8'hA5, 8'h00);
    #2 reset = 1'b1;
    #1;
    check_outs("t4.async", 8'h00, 8'h00, 8'h00);
    tick();
    check_outs("t4.held", 8'h00, 8'h00, 8'h00);
    #2 reset = 1'b0;
    repeat (LAT - 1) tick();
    check_outs("t4.lat", 8'h00, 8'h00, 8'h00);
    tick();
    check_outs("t4.edge", 8'hA5, 8'hA5, 8'h00);
    tick();
    check_outs("t4.once", 8'hA5, 8'h00, 8'h00);
    tick();
    check_outs("t4.once2", 8'hA5, 8'h00, 8'h00);

    // 6: bits 0 and 7 toggle together, both directions
    step("t6.fall", 8'hA5, 8'h24);
    step("t6.rise", 8'h24, 8'hA5);
    step("t6.back", 8'hA5, 8'h24);

`ifdef GLITCH_FILTER_EN
    // 5: bit 3 high for 3 cycles is rejected
    pad_in = 8'h2C;
    repeat (3) tick();
    pad_in = 8'h24;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      check_outs("t5.glitch", 8'h24, 8'h00, 8'h00);
    end
    // bit 3 high for 6 cycles passes after SYNC_STAGES+FILTER_CYCLES edges
    pad_in = 8'h2C;
    repeat (LAT - 1) tick();
    check_outs("t5.before", 8'h24, 8'h00, 8'h00);
    tick();
    check_outs("t5.edge", 8'h2C, 8'h08, 8'h00);
    pad_in = 8'h24;
    tick();
    check_outs("t5.after", 8'h2C, 8'h00, 8'h00);
`else
    // 5: a one-period pulse on bit 3 is always captured without the filter
    pad_in = 8'h2C;
    tick();
    pad_in = 8'h24;
    repeat (LAT - 2) tick();
    check_outs("t5.before", 8'h24, 8'h00, 8'h00);
    tick();
    check_outs("t5.edge", 8'h2C, 8'h08, 8'h00);
    tick();
    check_outs("t5.fall", 8'h24, 8'h00, 8'h08);
    tick();
    check_outs("t5.after", 8'h24, 8'h00, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ibuf_conditioner
`default_nettype wire

// File: doc/ibuf_conditioner.md
Name: ibuf_conditioner

Overview:
- Parameterised input-pad conditioning block that replaces the vendor IBUF/IBUFG primitives at the FPGA boundary.
- Provides three views of each pad:
  - a raw combinational pass-through (IBUF equivalent);
  - a dedicated clock-capable pass-through (IBUFG equivalent);
  - a synchronised, optionally glitch-filtered level with one-cycle rise/fall strobes for use in the `clock` domain.
- Sits between top-level pins (oscillator, ALE, ZIF inputs) and internal logic.

Parameters:
- WIDTH, 8, number of general input pads conditioned.
- SYNC_STAGES, 2, synchroniser flops per bit; legal range 2..4.
- RESET_LEVEL, 1'b0, value loaded into every synchroniser/filter/history flop on reset.
- FILTER_CYCLES, 4, consecutive stable cycles required before the filtered level changes. Used only with GLITCH_FILTER_EN; legal range 1..15.

Ports:
- clock  in  1  single system clock; all registers are posedge.
- reset  in  1  asynchronous, active-high reset.
- pad_in  in  WIDTH  raw pad inputs, asynchronous to `clock`.
- gclk_pad  in  1  clock-capable pad input.
- raw_out  out  WIDTH  combinational copy of pad_in (IBUF function).
- gclk_out  out  1  combinational copy of gclk_pad (IBUFG function).
- sync_out  out  WIDTH  synchronised (and filtered if enabled) level.
- rise_pulse  out  WIDTH  one-cycle strobe when sync_out bit goes 0->1.
- fall_pulse  out  WIDTH  one-cycle strobe when sync_out bit goes 1->0.

Behaviour:
- raw_out = pad_in and gclk_out = gclk_pad, both purely combinational.
  - No register, no reset dependency.
  - Values are valid during reset.
- Synchroniser:
  - Per bit, a chain of SYNC_STAGES flops; stage 0 samples pad_in.
  - The last stage is the "candidate" level.
  - Bits are fully independent; no multi-bit coherency is guaranteed.
- Without filter: sync_out = candidate.
  - A pad change stable before clock edge k is visible on sync_out after edge k+SYNC_STAGES-1, i.e. a latency of SYNC_STAGES edges.
- History register prev holds sync_out from the previous cycle.
  - rise_pulse = sync_out & ~prev.
  - fall_pulse = ~sync_out & prev.
  - Strobes are combinational from registers, high exactly during the first cycle of the new level.
  - Rise and fall are never both high on the same bit.
- Reset (asynchronous, any time including mid-transfer):
  - All synchroniser, filter, counter and prev flops are forced to RESET_LEVEL (counters to 0).
  - Consequently sync_out = RESET_LEVEL, and rise_pulse = fall_pulse = 0 immediately.
- After reset release with a pad at a level other than RESET_LEVEL:
  - The normal edge is reported after the synchroniser latency.
  - Exactly one strobe is produced.
- A pad pulse shorter than one clock period may be missed. This is allowed.
- A level change lasting at least one full period is always captured.

Optional Feature:
- Macro GLITCH_FILTER_EN.
- Defined:
  - Per bit, a filtered level register plus a counter of width clog2(FILTER_CYCLES+1).
  - When candidate != filtered, the counter increments each cycle.
  - When candidate == filtered, the counter clears to 0.
  - When the counter reaches FILTER_CYCLES-1 while candidate still differs, filtered takes candidate on that edge and the counter clears.
  - sync_out = filtered; total latency is SYNC_STAGES+FILTER_CYCLES edges.
  - Pulses shorter than FILTER_CYCLES cycles at the candidate are rejected.
  - Strobes are derived from the filtered level.
- Undefined:
  - No filter logic is generated and the FILTER_CYCLES parameter is ignored.

Decomposition:
- Package ibuf_conditioner_pkg holds:
  - default constants (DEF_WIDTH=8, DEF_SYNC_STAGES=2, DEF_FILTER_CYCLES=4);
  - the counter-width function.
- One sub-module, ibuf_cond_bit, handles a single bit: synchroniser, optional filter, history flop and strobes.
- The top instantiates it WIDTH times in a generate loop and adds the two combinational pass-throughs.

Test Plan:
1. Reset high, pad_in=8'hFF, gclk_pad toggling -> raw_out=8'hFF, gclk_out follows gclk_pad, sync_out=8'h00, rise_pulse=fall_pulse=8'h00.
2. Release reset, pad_in=8'h01 held, no filter -> sync_out[0] rises exactly 2 edges later; rise_pulse=8'h01 for exactly one cycle; all other bits stay 0.
3. pad_in 8'h01->8'h00 -> fall_pulse=8'h01 for one cycle 2 edges later; rise_pulse stays 0.
4. pad_in=8'hA5 settled, then reset asserted asynchronously between edges -> sync_out=8'h00 and strobes 0 immediately. After release, rise_pulse=8'hA5 once, following the synchroniser latency.
5. GLITCH_FILTER_EN, FILTER_CYCLES=4:
   - bit 3 high for 3 cycles -> sync_out[3] unchanged, no strobe;
   - high for 6 cycles -> sync_out[3] goes 1 at edge 2+4 after the change, rise_pulse[3] one cycle.
6. Independent toggles on bits 0 and 7 in the same cycle -> both strobes asserted in the same cycle, with identical latency.
